// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_e;

   // Per-cycle enables, flushes and bubbles for the PC and pipeline registers.
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic exmem_write;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic idex_bubble;
      logic memwb_bubble;
   } ctrl_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: hold once all-ones is reached.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes resolved in MEM, and data-memory wait freezes, with event counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W,
   parameter int unsigned CNT_W = pipe_ctrl_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ifid_rs1,
   input  logic [REG_W-1:0] ifid_rs2,
   input  logic             idex_mem_read,
   input  logic [REG_W-1:0] idex_rd,
   input  logic             exmem_mem_access,
   input  logic             exmem_branch_taken,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             idex_bubble,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] load_stall_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ctrl_state_e  state_q, state_d;
   ctrl_bundle_t ctrl;
   logic         load_use;
   logic         mem_wait;
   logic         load_inc, wait_inc, flush_inc;

   // x0 is hardwired to zero, so it never creates a dependency.
   assign load_use = idex_mem_read && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
   assign mem_wait = exmem_mem_access && !dmem_ready;

   // Next state and control outputs, evaluated in hazard priority order.
   always_comb begin
      state_d   = state_q;
      ctrl      = '0;
      dmem_req  = 1'b0;
      load_inc  = 1'b0;
      wait_inc  = 1'b0;
      flush_inc = 1'b0;

      unique case (state_q)
         BOOT: begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            state_d          = RUN;
         end
         RUN, MEM_WAIT: begin
            dmem_req = exmem_mem_access;
            if (mem_wait) begin
               // Freeze everything up to EX/MEM so the request stays stable.
               ctrl.memwb_bubble = 1'b1;
               wait_inc          = 1'b1;
               state_d           = MEM_WAIT;
            end else begin
               state_d = RUN;
               if (exmem_branch_taken) begin
                  // Writes stay enabled; the flushes override them.
                  ctrl.pc_write    = 1'b1;
                  ctrl.ifid_write  = 1'b1;
                  ctrl.idex_write  = 1'b1;
                  ctrl.exmem_write = 1'b1;
                  ctrl.ifid_flush  = 1'b1;
                  ctrl.idex_flush  = 1'b1;
                  ctrl.exmem_flush = 1'b1;
                  flush_inc        = 1'b1;
               end else if (load_use) begin
                  ctrl.idex_write  = 1'b1;
                  ctrl.exmem_write = 1'b1;
                  ctrl.idex_bubble = 1'b1;
                  load_inc         = 1'b1;
               end else begin
                  ctrl.pc_write    = 1'b1;
                  ctrl.ifid_write  = 1'b1;
                  ctrl.idex_write  = 1'b1;
                  ctrl.exmem_write = 1'b1;
               end
            end
         end
         default: state_d = BOOT;
      endcase

      // Everything is quiet while reset is held.
      if (reset) begin
         ctrl      = '0;
         dmem_req  = 1'b0;
         load_inc  = 1'b0;
         wait_inc  = 1'b0;
         flush_inc = 1'b0;
      end
   end

   // FSM state register; reset lands in BOOT regardless of any pending wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   assign pc_write     = ctrl.pc_write;
   assign ifid_write   = ctrl.ifid_write;
   assign idex_write   = ctrl.idex_write;
   assign exmem_write  = ctrl.exmem_write;
   assign ifid_flush   = ctrl.ifid_flush;
   assign idex_flush   = ctrl.idex_flush;
   assign exmem_flush  = ctrl.exmem_flush;
   assign idex_bubble  = ctrl.idex_bubble;
   assign memwb_bubble = ctrl.memwb_bubble;

   sat_counter #(.CNT_W(CNT_W)) u_load_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (load_inc),
      .count (load_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wait_inc),
      .count (mem_wait_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Counters are built 4 bits wide so
// saturation is reachable in a handful of cycles.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [REG_W-1:0] ifid_rs1, ifid_rs2, idex_rd;
   logic             idex_mem_read, exmem_mem_access, exmem_branch_taken, dmem_ready;
   logic             dmem_req, pc_write, ifid_write, idex_write, exmem_write;
   logic             ifid_flush, idex_flush, exmem_flush, idex_bubble, memwb_bubble;
   logic [CNT_W-1:0] load_stall_cnt, mem_wait_cnt, flush_cnt;

   int passed = 0;
   int total  = 0;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .ifid_rs1           (ifid_rs1),
      .ifid_rs2           (ifid_rs2),
      .idex_mem_read      (idex_mem_read),
      .idex_rd            (idex_rd),
      .exmem_mem_access   (exmem_mem_access),
      .exmem_branch_taken (exmem_branch_taken),
      .dmem_ready         (dmem_ready),
      .dmem_req           (dmem_req),
      .pc_write           (pc_write),
      .ifid_write         (ifid_write),
      .idex_write         (idex_write),
      .exmem_write        (exmem_write),
      .ifid_flush         (ifid_flush),
      .idex_flush         (idex_flush),
      .exmem_flush        (exmem_flush),
      .idex_bubble        (idex_bubble),
      .memwb_bubble       (memwb_bubble),
      .load_stall_cnt     (load_stall_cnt),
      .mem_wait_cnt       (mem_wait_cnt),
      .flush_cnt          (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Writes packed as {pc, ifid, idex, exmem}; flushes as {ifid, idex, exmem}.
   function automatic logic [31:0] writes();
      return {28'd0, pc_write, ifid_write, idex_write, exmem_write};
   endfunction

   function automatic logic [31:0] flushes();
      return {29'd0, ifid_flush, idex_flush, exmem_flush};
   endfunction

   // Advance one edge, leaving time 1 past it for input changes.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifid_rs1           = '0;
      ifid_rs2           = '0;
      idex_rd            = '0;
      idex_mem_read      = 1'b0;
      exmem_mem_access   = 1'b0;
      exmem_branch_taken = 1'b0;
      dmem_ready         = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();

      // Reset held for two edges.
      tick();
      tick();
      #1;
      check("rst_writes", writes(), 32'h0);
      check("rst_flushes", flushes(), 32'h0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'h0);
      check("rst_cnts", {20'd0, load_stall_cnt, mem_wait_cnt, flush_cnt}, 32'h0);

      // BOOT cycle.
      reset = 1'b0;
      #1;
      check("boot_flushes", flushes(), 32'h7);
      check("boot_writes", writes(), 32'h0);
      check("boot_dmem_req", {31'd0, dmem_req}, 32'h0);
      tick();

      // First RUN cycle, no hazards.
      #1;
      check("run_writes", writes(), 32'hF);
      check("run_flushes", flushes(), 32'h0);
      check("run_bubbles", {30'd0, idex_bubble, memwb_bubble}, 32'h0);
      check("run_cnts", {20'd0, load_stall_cnt, mem_wait_cnt, flush_cnt}, 32'h0);

      // Load-use on rs2.
      idex_mem_read = 1'b1;
      idex_rd       = 5'd5;
      ifid_rs2      = 5'd5;
      #1;
      check("lu_writes", writes(), 32'h3);
      check("lu_bubble", {31'd0, idex_bubble}, 32'h1);
      check("lu_flushes", flushes(), 32'h0);
      tick();
      check("lu_cnt", {28'd0, load_stall_cnt}, 32'h1);

      // Load into x0 never stalls.
      idex_rd  = 5'd0;
      ifid_rs1 = 5'd0;
      ifid_rs2 = 5'd0;
      #1;
      check("x0_writes", writes(), 32'hF);
      check("x0_bubble", {31'd0, idex_bubble}, 32'h0);
      tick();
      check("x0_cnt", {28'd0, load_stall_cnt}, 32'h1);

      // Memory wait of 3 cycles with a taken branch pending behind it.
      idle_inputs();
      exmem_mem_access   = 1'b1;
      exmem_branch_taken = 1'b1;
      dmem_ready         = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mw_dmem_req", {31'd0, dmem_req}, 32'h1);
         check("mw_writes", writes(), 32'h0);
         check("mw_flushes", flushes(), 32'h0);
         check("mw_memwb_bubble", {31'd0, memwb_bubble}, 32'h1);
         tick();
      end
      check("mw_cnt", {28'd0, mem_wait_cnt}, 32'h3);
      check("mw_flush_cnt_hold", {28'd0, flush_cnt}, 32'h0);

      dmem_ready = 1'b1;
      #1;
      check("mw_rel_flushes", flushes(), 32'h7);
      check("mw_rel_pc_write", {31'd0, pc_write}, 32'h1);
      check("mw_rel_memwb_bubble", {31'd0, memwb_bubble}, 32'h0);
      tick();
      check("mw_rel_flush_cnt", {28'd0, flush_cnt}, 32'h1);
      check("mw_rel_wait_cnt", {28'd0, mem_wait_cnt}, 32'h3);

      // Branch and load-use together: branch wins.
      idle_inputs();
      exmem_branch_taken = 1'b1;
      idex_mem_read      = 1'b1;
      idex_rd            = 5'd7;
      ifid_rs1           = 5'd7;
      #1;
      check("bl_flushes", flushes(), 32'h7);
      check("bl_pc_write", {31'd0, pc_write}, 32'h1);
      check("bl_bubble", {31'd0, idex_bubble}, 32'h0);
      tick();
      check("bl_flush_cnt", {28'd0, flush_cnt}, 32'h2);
      check("bl_load_cnt", {28'd0, load_stall_cnt}, 32'h1);

      // Drive load_stall_cnt from 1 to 14 (all-ones minus one).
      exmem_branch_taken = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      check("sat_pre", {28'd0, load_stall_cnt}, 32'hE);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_hold", {28'd0, load_stall_cnt}, 32'hF);
      end

      // Reset asserted on the second cycle of a memory wait.
      idle_inputs();
      exmem_mem_access = 1'b1;
      dmem_ready       = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("rw_rst_dmem_req", {31'd0, dmem_req}, 32'h0);
      check("rw_rst_writes", writes(), 32'h0);
      tick();
      reset = 1'b0;
      #1;
      check("rw_boot_dmem_req", {31'd0, dmem_req}, 32'h0);
      check("rw_boot_flushes", flushes(), 32'h7);
      check("rw_boot_memwb_bubble", {31'd0, memwb_bubble}, 32'h0);
      check("rw_boot_cnts", {20'd0, load_stall_cnt, mem_wait_cnt, flush_cnt}, 32'h0);
      tick();
      #1;
      check("rw_run_dmem_req", {31'd0, dmem_req}, 32'h1);
      check("rw_run_writes", writes(), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
